log_reader: RTL and testbench

- Read-side sequencer for the DSP capture log memory (single-port, 22-bit, HIGH_PERFORMANCE output register).
- The address counter writes FIR samples into the memory. This block reads a requested number of words back starting at address 0 and presents each word on a valid/ready stream toward the register file or the micro.
- Drives the memory address, enable and output-register-enable itself, hiding the 2-cycle read latency from the consumer.
- Runs on clock (the DSP clock domain).

---
 rtl/log_reader.sv | 145 ++++++++++++++
 tb/tb_log_reader.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/log_reader.sv
// rtl/log_reader.sv - read-side sequencer for the DSP capture log memory
//
// Reads i_length words (0 means the full 2**N_ADDR depth) starting at address 0
// from a single-port memory with a 2-cycle registered read path. Each word is
// offered on a valid/ready stream, and the memory read latency is hidden behind
// a fixed ISSUE -> LATCH -> CAPTURE -> PRESENT sequence per word.
//
// Optional build macro: LOG_READER_CHECKSUM_EN adds o_checksum, the running
// sum (mod 2**RAM_WIDTH) of every word handed over in the current transfer.
//
// Ports:
//   clock        in   DSP clock, rising edge
//   i_reset      in   synchronous active-low reset
//   i_start      in   start request, honoured only when idle
//   i_abort      in   stop the transfer, honoured only when busy
//   i_length     in   words to read, 0 = 2**N_ADDR
//   o_mem_addr   out  memory read address
//   o_mem_en     out  memory enable (address capture)
//   o_mem_regce  out  memory output register enable
//   i_mem_data   in   memory read data (douta)
//   o_data       out  presented word (registered)
//   o_valid      out  o_data valid
//   i_ready      in   consumer accepts o_data on o_valid && i_ready
//   o_busy       out  high whenever not idle
//   o_done       out  one-cycle pulse at the end of a transfer or abort
//   o_checksum   out  running word sum (LOG_READER_CHECKSUM_EN only)

module log_reader #(
  parameter int N_ADDR    = 10,
  parameter int RAM_WIDTH = 22
) (
  input  logic                 clock,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [N_ADDR-1:0]    i_length,
  output logic [N_ADDR-1:0]    o_mem_addr,
  output logic                 o_mem_en,
  output logic                 o_mem_regce,
  input  logic [RAM_WIDTH-1:0] i_mem_data,
  output logic [RAM_WIDTH-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_busy,
  output logic                 o_done
`ifdef LOG_READER_CHECKSUM_EN
  , output logic [RAM_WIDTH-1:0] o_checksum
`endif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    LATCH   = 3'd2,
    CAPTURE = 3'd3,
    PRESENT = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [N_ADDR:0]   CNT_ONE  = {{N_ADDR{1'b0}}, 1'b1};
  localparam logic [N_ADDR:0]   CNT_FULL = {1'b1, {N_ADDR{1'b0}}};
  localparam logic [N_ADDR-1:0] ADDR_ONE = {{(N_ADDR-1){1'b0}}, 1'b1};

  state_t          state;
  state_t          state_nxt;
  // One bit wider than the address so a full-depth transfer can be counted.
  logic [N_ADDR:0] remaining;
  logic            handshake;

  // o_valid is only ever high in PRESENT, so this is the consumer handshake.
  assign handshake = o_valid && i_ready;

  // Strobes decoded purely from state so i_ready never reaches an output.
  assign o_mem_en    = (state == ISSUE);
  assign o_mem_regce = (state == LATCH);
  assign o_busy      = (state != IDLE);
  assign o_done      = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = ISSUE;
      ISSUE:   state_nxt = i_abort ? DONE : LATCH;
      LATCH:   state_nxt = i_abort ? DONE : CAPTURE;
      CAPTURE: state_nxt = i_abort ? DONE : PRESENT;
      PRESENT: begin
        // Abort wins over issuing the next word.
        if (i_abort)
          state_nxt = DONE;
        else if (handshake)
          state_nxt = (remaining == CNT_ONE) ? DONE : ISSUE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!i_reset) begin
      state      <= IDLE;
      remaining  <= '0;
      o_mem_addr <= '0;
      o_data     <= '0;
      o_valid    <= 1'b0;
`ifdef LOG_READER_CHECKSUM_EN
      o_checksum <= '0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (i_start) begin
            remaining  <= (i_length == '0) ? CNT_FULL : {1'b0, i_length};
            o_mem_addr <= '0;
`ifdef LOG_READER_CHECKSUM_EN
            o_checksum <= '0;
`endif
          end
        end
        CAPTURE: begin
          if (!i_abort) begin
            o_data  <= i_mem_data;
            o_valid <= 1'b1;
          end
        end
        PRESENT: begin
          // A handshake coinciding with abort still counts as delivered.
          if (handshake) begin
            o_valid    <= 1'b0;
            remaining  <= remaining - CNT_ONE;
            // Wraps to 0 after the last word of a full-depth read.
            o_mem_addr <= o_mem_addr + ADDR_ONE;
`ifdef LOG_READER_CHECKSUM_EN
            o_checksum <= o_checksum + o_data;
`endif
          end
          if (i_abort)
            o_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_log_reader.sv
// tb/tb_log_reader.sv - self-checking bench for log_reader

module tb_log_reader;

  localparam int N_ADDR    = 10;
  localparam int RAM_WIDTH = 22;
  localparam int DEPTH     = 1 << N_ADDR;

  logic                 clock = 1'b0;
  logic                 i_reset = 1'b0;
  logic                 i_start = 1'b0;
  logic                 i_abort = 1'b0;
  logic [N_ADDR-1:0]    i_length = '0;
  logic [N_ADDR-1:0]    o_mem_addr;
  logic                 o_mem_en;
  logic                 o_mem_regce;
  logic [RAM_WIDTH-1:0] i_mem_data;
  logic [RAM_WIDTH-1:0] o_data;
  logic                 o_valid;
  logic                 i_ready = 1'b0;
  logic                 o_busy;
  logic                 o_done;
`ifdef LOG_READER_CHECKSUM_EN
  logic [RAM_WIDTH-1:0] o_checksum;
`endif

  always #5 clock = ~clock;

  log_reader #(.N_ADDR(N_ADDR), .RAM_WIDTH(RAM_WIDTH)) dut (
    .clock      (clock),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .i_abort    (i_abort),
    .i_length   (i_length),
    .o_mem_addr (o_mem_addr),
    .o_mem_en   (o_mem_en),
    .o_mem_regce(o_mem_regce),
    .i_mem_data (i_mem_data),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_busy     (o_busy),
    .o_done     (o_done)
`ifdef LOG_READER_CHECKSUM_EN
    , .o_checksum(o_checksum)
`endif
  );

  // Behavioural single-port memory: address captured on en, output register on regce.
  logic [RAM_WIDTH-1:0] mem [DEPTH];
  logic [RAM_WIDTH-1:0] mem_lat = '0;
  logic [RAM_WIDTH-1:0] mem_dout = '0;
  always @(posedge clock) begin
    if (o_mem_en)    mem_lat  <= mem[o_mem_addr];
    if (o_mem_regce) mem_dout <= mem_lat;
  end
  assign i_mem_data = mem_dout;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Results of the most recent run_xfer.
  logic [RAM_WIDTH-1:0] got_q[$];
  int addr_q[$];
  int rise_q[$];
  int done_cnt, done_rel, hs_rel, en_cnt;
  bit timed_out;

  task automatic tick;
    @(posedge clock);
    cyc++;
    #1;
  endtask

  task automatic fill_random;
    for (int k = 0; k < DEPTH; k++) mem[k] = RAM_WIDTH'($urandom);
  endtask

  // Runs one transfer. Cycle offsets are counted in edges from the edge after
  // which i_start is driven (edge 0).
  task automatic run_xfer(input int len, input int ready_pct, input int abort_rel,
                          input bit start_noise);
    int t0, rel;
    bit prev_valid, seen_done;
    got_q.delete(); addr_q.delete(); rise_q.delete();
    done_cnt = 0; done_rel = -1; hs_rel = -1; en_cnt = 0; timed_out = 0;
    prev_valid = 0; seen_done = 0;
    i_length = len[N_ADDR-1:0];
    i_start = 1'b1;
    t0 = cyc;
    tick;
    i_start = 1'b0;
    for (int n = 0; n < 20000 && !seen_done; n++) begin
      rel = cyc - t0;
      if (o_mem_en) en_cnt++;
      if (o_valid && !prev_valid) rise_q.push_back(rel);
      prev_valid = o_valid;
      if (o_done) begin
        done_cnt++; done_rel = rel; seen_done = 1;
        i_ready = 1'b0; i_abort = 1'b0; i_start = 1'b0;
      end else begin
        i_ready = (int'($urandom_range(99)) < ready_pct);
        i_abort = (rel == abort_rel);
        i_start = start_noise ? 1'($urandom_range(1)) : 1'b0;
        if (o_valid && i_ready) begin
          got_q.push_back(o_data);
          addr_q.push_back(int'(o_mem_addr));
          hs_rel = rel + 1;
        end
      end
      tick;
    end
    timed_out = !seen_done;
    i_ready = 1'b0; i_abort = 1'b0; i_start = 1'b0;
  endtask

  task automatic test_reset;
    i_reset = 1'b0;
    tick; tick;
    checks++;
    if ({o_mem_addr, o_mem_en, o_mem_regce, o_data, o_valid, o_busy, o_done} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: addr=%0h en=%b regce=%b data=%0h valid=%b busy=%b done=%b, required all zero",
               o_mem_addr, o_mem_en, o_mem_regce, o_data, o_valid, o_busy, o_done);
    end
`ifdef LOG_READER_CHECKSUM_EN
    checks++;
    if (o_checksum !== '0) begin
      failures++;
      $display("FAIL reset_checksum: got %0h required 0", o_checksum);
    end
`endif
    i_reset = 1'b1;
    tick;
  endtask

  task automatic test_basic;
    int exp_rise[3] = '{4, 8, 12};
    int bad;
    for (int k = 0; k < DEPTH; k++) mem[k] = 22'h3F000 + RAM_WIDTH'(k);
    run_xfer(3, 100, -1, 0);
    checks++;
    if (timed_out || got_q.size() != 3) begin
      failures++;
      $display("FAIL basic_count: got %0d words (timeout=%0b) required 3", got_q.size(), timed_out);
    end else begin
      bad = 0;
      for (int k = 0; k < 3; k++) if (got_q[k] !== 22'h3F000 + RAM_WIDTH'(k)) bad++;
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL basic_data: words %0h %0h %0h required 3f000 3f001 3f002", got_q[0], got_q[1], got_q[2]);
      end
    end
    checks++;
    if (rise_q.size() != 3 || rise_q[0] != exp_rise[0] || rise_q[1] != exp_rise[1] || rise_q[2] != exp_rise[2]) begin
      failures++;
      $display("FAIL basic_timing: valid rises at %p required '{4,8,12}", rise_q);
    end
    checks++;
    if (done_cnt != 1 || done_rel != hs_rel || done_rel != 13) begin
      failures++;
      $display("FAIL basic_done: done_cnt=%0d done_at=%0d last_hs=%0d required 1 pulse at 13", done_cnt, done_rel, hs_rel);
    end
    checks++;
    if (o_busy !== 1'b0 || en_cnt != 3) begin
      failures++;
      $display("FAIL basic_idle: busy=%b mem_en cycles=%0d required busy 0, 3 cycles", o_busy, en_cnt);
    end
  endtask

  task automatic test_backpressure;
    int bad, gap, n;
    fill_random();
    i_length = 2; i_start = 1'b1; i_ready = 1'b0;
    tick;
    i_start = 1'b0;
    n = 0;
    while (!o_valid && n < 20) begin tick; n++; end
    checks++;
    if (!o_valid) begin
      failures++;
      $display("FAIL bp_first_valid: valid=%b after %0d cycles required 1", o_valid, n);
    end
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (o_data !== mem[0] || o_mem_en !== 1'b0 || o_valid !== 1'b1) bad++;
      tick;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bp_hold: %0d of 10 stall cycles unstable, data=%0h required %0h", bad, o_data, mem[0]);
    end
    i_ready = 1'b1;
    gap = 0;
    do begin tick; gap++; end while (!o_valid && gap < 20);
    checks++;
    if (gap != 4 || o_data !== mem[1]) begin
      failures++;
      $display("FAIL bp_next_word: appeared after %0d cycles data=%0h required 4 cycles data=%0h", gap, o_data, mem[1]);
    end
    n = 0;
    while (!o_done && n < 20) begin tick; n++; end
    checks++;
    if (!o_done) begin
      failures++;
      $display("FAIL bp_done: done=%b required 1 within 20 cycles", o_done);
    end
    i_ready = 1'b0;
    tick;
  endtask

  task automatic test_full_depth;
    int bad;
    fill_random();
    run_xfer(0, 80, -1, 1);
    bad = 0;
    for (int k = 0; k < got_q.size(); k++)
      if (addr_q[k] != k || got_q[k] !== mem[k]) bad++;
    checks++;
    if (timed_out || got_q.size() != DEPTH || bad != 0) begin
      failures++;
      $display("FAIL full_depth: %0d words, %0d out of order (timeout=%0b) required %0d in order",
               got_q.size(), bad, timed_out, DEPTH);
    end
    checks++;
    if (o_mem_addr !== '0 || done_cnt != 1 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL full_depth_end: addr=%0h done_cnt=%0d busy=%b required addr 0, 1 pulse, busy 0",
               o_mem_addr, done_cnt, o_busy);
    end
  endtask

  task automatic test_abort;
    fill_random();
    // Word k is in LATCH at edge offset 4k+2, so word 2 latches at offset 10.
    run_xfer(8, 100, 10, 0);
    checks++;
    if (got_q.size() != 2 || got_q[0] !== mem[0] || got_q[1] !== mem[1] || rise_q.size() != 2) begin
      failures++;
      $display("FAIL abort_words: got %0d words, %0d valid rises, required 2 words %0h %0h",
               got_q.size(), rise_q.size(), mem[0], mem[1]);
    end
    checks++;
    if (done_cnt != 1 || done_rel != 11 || en_cnt != 3 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_end: done_cnt=%0d done_at=%0d mem_en cycles=%0d busy=%b required 1 at 11, 3 cycles, busy 0",
               done_cnt, done_rel, en_cnt, o_busy);
    end
  endtask

  task automatic test_random;
    int len, pct, bad, spacing_bad;
    logic [RAM_WIDTH-1:0] sum;
    for (int it = 0; it < 6; it++) begin
      fill_random();
      len = $urandom_range(24, 1);
      pct = $urandom_range(100, 30);
      run_xfer(len, pct, -1, 1);
      bad = 0; spacing_bad = 0; sum = '0;
      for (int k = 0; k < got_q.size(); k++) begin
        if (k >= len || got_q[k] !== mem[k] || addr_q[k] != k) bad++;
        if (k < len) sum = sum + mem[k];
      end
      for (int k = 1; k < rise_q.size(); k++) if (rise_q[k] - rise_q[k-1] < 4) spacing_bad++;
      checks++;
      if (timed_out || got_q.size() != len || bad != 0 || spacing_bad != 0 || done_cnt != 1) begin
        failures++;
        $display("FAIL random_xfer[%0d]: len=%0d got=%0d bad=%0d spacing_bad=%0d done_cnt=%0d timeout=%0b",
                 it, len, got_q.size(), bad, spacing_bad, done_cnt, timed_out);
      end
`ifdef LOG_READER_CHECKSUM_EN
      checks++;
      if (o_checksum !== sum) begin
        failures++;
        $display("FAIL random_checksum[%0d]: got %0h required %0h", it, o_checksum, sum);
      end
`endif
    end
  endtask

  task automatic test_reset_mid;
    int n, done_seen;
    fill_random();
    i_length = 4; i_start = 1'b1; i_ready = 1'b0;
    tick;
    i_start = 1'b0;
    n = 0;
    while (!o_valid && n < 20) begin tick; n++; end
    i_ready = 1'b1;   // accept word 0 so the address has moved off 0
    tick;
    i_ready = 1'b0;
    n = 0;
    while (!o_valid && n < 20) begin tick; n++; end
    i_reset = 1'b0;
    tick;
    i_reset = 1'b1;
    checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_mem_addr !== '0 || o_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: valid=%b busy=%b addr=%0h done=%b required all 0",
               o_valid, o_busy, o_mem_addr, o_done);
    end
    done_seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (o_done || o_busy) done_seen++;
      tick;
    end
    checks++;
    if (done_seen != 0) begin
      failures++;
      $display("FAIL reset_mid_quiet: %0d cycles with done or busy, required 0", done_seen);
    end
  endtask

`ifdef LOG_READER_CHECKSUM_EN
  task automatic test_checksum;
    logic [RAM_WIDTH-1:0] exp_sum;
    mem[0] = 22'h3FFFFF;
    mem[1] = 22'h000002;
    exp_sum = mem[0] + mem[1];
    run_xfer(2, 100, -1, 0);
    checks++;
    if (o_checksum !== exp_sum) begin
      failures++;
      $display("FAIL checksum_wrap: got %0h required %0h", o_checksum, exp_sum);
    end
    i_length = 1; i_start = 1'b1;
    tick;
    i_start = 1'b0;
    checks++;
    if (o_checksum !== '0) begin
      failures++;
      $display("FAIL checksum_clear: got %0h required 0", o_checksum);
    end
    for (int c = 0; c < 12 && o_busy; c++) begin i_ready = 1'b1; tick; end
    i_ready = 1'b0;
    tick;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_abort();
    test_random();
    test_full_depth();
    test_reset_mid();
`ifdef LOG_READER_CHECKSUM_EN
    test_checksum();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
